note_env_synth: RTL
===================

Name: note_env_synth

Overview:
- Parametrised successor to the three-key note/volume selector.
- Maps N one-per-note key inputs to a tone divider and signed amplitude pair (vol / vol_minus) for the downstream square-wave generator and audio serialiser.
- Adds registered key sampling, a user volume level with up/down pulses, and an attack/sustain/release amplitude envelope stepped on a programmable tick.

Parameters:
- N_KEYS, 8, number of key inputs; index 0 = lowest note.
- DIV_W, 22, width of note_div.
- AMP_W, 16, width of vol / vol_minus.
- NOTE_TABLE, {95511,101215,113636,127551,143266,151515,170648,191571} packed DIV_W each, entry i at bits [i*DIV_W +: DIV_W] (entry 0 = 191571, do).
- MAX_LEVEL, 7, highest volume level; levels 0..MAX_LEVEL.
- VOL_INIT, 4, volume level after reset.
- LEVEL_AMP, 16'h0FFF, amplitude per level; target = level*LEVEL_AMP, must be ≤ 2^(AMP_W-1)-1.
- ENV_STEP, 16'h0400, amplitude change per tick.
- TICK_DIV, 100000, clocks per envelope tick (≥2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key  input  N_KEYS  debounced key levels, 1 = pressed
- vol_up  input  1  one-cycle pulse, raise level
- vol_down  input  1  one-cycle pulse, lower level
- note_div  output  DIV_W  tone divider, 0 = silent
- vol  output  AMP_W  positive amplitude
- vol_minus  output  AMP_W  two's-complement negative of vol
- vol_level  output  3  current volume level (width covers MAX_LEVEL)
- busy  output  1  1 when envelope state ≠ IDLE

Behaviour:
- Reset (async, rst_n=0): key_q=0, state=IDLE, note_div=0, vol=0, vol_minus=0, vol_level=VOL_INIT, tick counter=0, busy=0. Release of reset takes effect on the next clk edge.
- Key sampling: key registered into key_q every edge.
  - "valid" = key_q has exactly one bit set.
  - sel = index of that bit.
  - Zero or multiple bits set = no valid key (same rule as the original selector).
- Latency: key change at edge k appears in key_q at k; state and note_div update at edge k+1.
- Tick: counter 0..TICK_DIV-1, free-running, not reset by key activity. tick=1 in the cycle where counter==TICK_DIV-1.
- Volume level, updated every edge independently of envelope:
  - vol_up alone: +1, saturates at MAX_LEVEL.
  - vol_down alone: -1, saturates at 0.
  - Both set, or neither: no change.
  - target = vol_level*LEVEL_AMP, using the registered level.
- States: IDLE, ATTACK, SUSTAIN, RELEASE.
  - IDLE: note_div=0, vol=0.
    - valid -> ATTACK; note_div=NOTE_TABLE[sel] on the same edge.
  - ATTACK: on tick, vol steps toward target.
    - Up: min(vol+ENV_STEP, target). Down: max(vol-ENV_STEP, target). Compute in AMP_W+1 bits; no wrap.
    - vol==target after the step -> SUSTAIN.
  - SUSTAIN: vol==target held.
    - If target changes (level change), -> ATTACK and step toward the new target.
  - RELEASE: on tick, vol = max(vol-ENV_STEP, 0); note_div holds the last note.
    - vol reaches 0 -> IDLE; note_div=0 on that same edge.
  - From ATTACK, SUSTAIN or RELEASE:
    - not valid -> RELEASE. Takes priority over any tick step that edge; the step is still applied, downward toward 0.
    - valid with sel ≠ latched note -> retrigger: note_div=NOTE_TABLE[sel] immediately, -> ATTACK from the current vol (no reset to 0).
    - valid with the same sel in RELEASE (re-press) -> ATTACK, note unchanged.
- vol_minus = (~vol)+1 registered alongside vol; 0 when vol=0.
- Level 0 during a held key: target 0. ATTACK ramps down to 0 then SUSTAIN; note_div stays non-zero, busy=1.
- Reset mid-ramp: all outputs return to reset values immediately (async).
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- TICK_DIV=4, ENV_STEP=16'h1000, level 4 (target 16'h3FFC). Set key=8'b0000_0001 -> note_div=191571 two edges later, state ATTACK. vol steps 0x1000, 0x2000, 0x3000, 0x3FFC on successive ticks, then SUSTAIN. vol_minus=16'hC004 at sustain.
- During sustain, set key=8'b0000_0011 -> RELEASE. vol falls by 0x1000 per tick to 0. note_div holds 191571 until the edge vol hits 0, then note_div=0, busy=0.
- During sustain on key 0, switch key to 8'b0000_0100 -> note_div=151515 next-but-one edge. vol continues from 0x3FFC with no dip; state passes ATTACK then SUSTAIN.
- vol_up pulsed 5 times from level 4 -> vol_level saturates at 7 (target 0x6FF9), vol ramps up. vol_up and vol_down pulsed together -> level unchanged. vol_down ×9 -> level 0, vol ramps to 0, note_div still set.
- Key 2 held mid-ATTACK (vol=0x2000), assert rst_n=0 -> same cycle note_div=0, vol=0, vol_minus=0, vol_level=4, busy=0. Release rst_n with key still held -> fresh ATTACK from 0.
- Key released and re-pressed (same key) during RELEASE at vol=0x2000 -> ATTACK resumes upward from 0x2000, note_div unchanged throughout.

Source files
------------

// File: rtl/note_env_synth.sv
// Maps one-hot key inputs to a tone divider and drives a signed amplitude pair
// through an attack/sustain/release envelope, scaled by a user volume level.
module note_env_synth #(
    parameter int                      N_KEYS     = 8,
    parameter int                      DIV_W      = 22,
    parameter int                      AMP_W      = 16,
    parameter logic [N_KEYS*DIV_W-1:0] NOTE_TABLE = {22'd95511,  22'd101215, 22'd113636, 22'd127551,
                                                     22'd143266, 22'd151515, 22'd170648, 22'd191571},
    parameter int                      MAX_LEVEL  = 7,
    parameter int                      VOL_INIT   = 4,
    parameter logic [AMP_W-1:0]        LEVEL_AMP  = 16'h0FFF,
    parameter logic [AMP_W-1:0]        ENV_STEP   = 16'h0400,
    parameter int                      TICK_DIV   = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    input  logic              vol_up,
    input  logic              vol_down,
    output logic [DIV_W-1:0]  note_div,
    output logic [AMP_W-1:0]  vol,
    output logic [AMP_W-1:0]  vol_minus,
    output logic [2:0]        vol_level,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam int               SEL_W    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]       LVL_MAX  = 3'(MAX_LEVEL);
    localparam logic [2:0]       LVL_INIT = 3'(VOL_INIT);

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [N_KEYS-1:0]  key_q, key_d;
    logic [DIV_W-1:0]   note_div_q, note_div_d;
    logic [SEL_W-1:0]   note_sel_q, note_sel_d;
    logic [AMP_W-1:0]   vol_q, vol_d;
    logic [AMP_W-1:0]   vol_minus_q, vol_minus_d;
    logic [2:0]         level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               valid, found, multi, tick;
    logic [SEL_W-1:0]   sel;
    logic [DIV_W-1:0]   sel_div;
    logic [AMP_W-1:0]   target, step_toward, step_rel;
    logic [AMP_W:0]     up_sum, down_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            note_div_q  <= '0;
            note_sel_q  <= '0;
            vol_q       <= '0;
            vol_minus_q <= '0;
            level_q     <= LVL_INIT;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            note_div_q  <= note_div_d;
            note_sel_q  <= note_sel_d;
            vol_q       <= vol_d;
            vol_minus_q <= vol_minus_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    // A key is valid only when exactly one bit of the sampled vector is set.
    always_comb begin
        key_d   = key;
        found   = 1'b0;
        multi   = 1'b0;
        sel     = '0;
        sel_div = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (key_q[i]) begin
                if (found) multi = 1'b1;
                found   = 1'b1;
                sel     = SEL_W'(i);
                sel_div = NOTE_TABLE[i*DIV_W +: DIV_W];
            end
        end
        valid = found & ~multi;
    end

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        level_d = level_q;
        if (vol_up && !vol_down && level_q != LVL_MAX) begin
            level_d = level_q + 3'd1;
        end else if (vol_down && !vol_up && level_q != 3'd0) begin
            level_d = level_q - 3'd1;
        end
    end

    assign target = {{(AMP_W-3){1'b0}}, level_q} * LEVEL_AMP;

    // Envelope steps use one extra bit so neither direction can wrap.
    always_comb begin
        up_sum    = {1'b0, vol_q} + {1'b0, ENV_STEP};
        down_diff = {1'b0, vol_q} - {1'b0, ENV_STEP};
        step_rel  = down_diff[AMP_W] ? '0 : down_diff[AMP_W-1:0];
        if (vol_q < target) begin
            step_toward = (up_sum > {1'b0, target}) ? target : up_sum[AMP_W-1:0];
        end else if (vol_q > target) begin
            step_toward = (down_diff[AMP_W] || down_diff[AMP_W-1:0] < target) ? target
                                                                              : down_diff[AMP_W-1:0];
        end else begin
            step_toward = vol_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid) state_d = ATTACK;
            end
            default: begin
                if (!valid) begin
                    if (state_q == RELEASE && tick && step_rel == '0) state_d = IDLE;
                    else state_d = RELEASE;
                end else if (sel != note_sel_q) begin
                    state_d = ATTACK;
                end else begin
                    case (state_q)
                        ATTACK:  if (tick && step_toward == target) state_d = SUSTAIN;
                        SUSTAIN: if (vol_q != target) state_d = ATTACK;
                        default: state_d = ATTACK;
                    endcase
                end
            end
        endcase
    end

    // Retriggers keep the current amplitude; only the note changes.
    always_comb begin
        vol_d      = vol_q;
        note_div_d = note_div_q;
        note_sel_d = note_sel_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    note_div_d = sel_div;
                    note_sel_d = sel;
                end
            end
            default: begin
                if (!valid) begin
                    if (tick) vol_d = step_rel;
                end else if (sel != note_sel_q) begin
                    note_div_d = sel_div;
                    note_sel_d = sel;
                end else if (state_q == ATTACK && tick) begin
                    vol_d = step_toward;
                end
            end
        endcase
        if (state_d == IDLE) note_div_d = '0;
        vol_minus_d = (~vol_d) + AMP_W'(1);
        busy_d      = (state_d != IDLE);
    end

    assign note_div  = note_div_q;
    assign vol       = vol_q;
    assign vol_minus = vol_minus_q;
    assign vol_level = level_q;
    assign busy      = busy_q;

endmodule
